// File: rtl/debounce_multi_pkg.sv
// Shared constants and helpers for the multi-channel switch debouncer.
package debounce_multi_pkg;

  localparam int CLKS_PER_MS = 25000;

  // Counter width for a limit; never narrower than one bit.
  function automatic int cnt_width(input int limit);
    return (limit > 2) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: synchroniser, stability counter, press/release pulses, long-press detect.
// Level and edge pulses change SYNC_STAGES + DEBOUNCE_LIMIT clocks after a clean input edge.
module debounce_channel
  import debounce_multi_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = 10 * CLKS_PER_MS,
  parameter int LONG_LIMIT     = 1000 * CLKS_PER_MS,
  parameter int SYNC_STAGES    = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic switch_raw,
  output logic level,
  output logic press,
  output logic rel,
  output logic long_press
);

  localparam int DB_W   = cnt_width(DEBOUNCE_LIMIT);
  localparam int LONG_W = cnt_width(LONG_LIMIT);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_LIMIT - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [DB_W-1:0]        db_cnt;
  logic [LONG_W-1:0]      hold_cnt;
  logic                   long_fired;
  logic                   sync_bit;

  assign sync_bit = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= '0;
      db_cnt <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
      rel    <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], switch_raw};
      press <= 1'b0;
      rel   <= 1'b0;
      // Any agreeing sample restarts the stability window.
      if (sync_bit == level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        level  <= sync_bit;
        db_cnt <= '0;
        press  <= sync_bit;
        rel    <= ~sync_bit;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Hold counter parks at its last value once fired, so one pulse per press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt   <= '0;
      long_fired <= 1'b0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (!level) begin
        hold_cnt   <= '0;
        long_fired <= 1'b0;
      end else if (!long_fired) begin
        if (hold_cnt == LONG_LAST) begin
          long_press <= 1'b1;
          long_fired <= 1'b1;
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/debounce_multi.sv
// NUM_CH independent switch debouncers with clean levels and press/release/long-press pulses.
// Each channel reacts SYNC_STAGES + DEBOUNCE_LIMIT clocks after a clean edge; no flow control.
module debounce_multi
  import debounce_multi_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int DEBOUNCE_LIMIT = 10 * CLKS_PER_MS,
  parameter int LONG_LIMIT     = 1000 * CLKS_PER_MS,
  parameter int SYNC_STAGES    = 2
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic [NUM_CH-1:0] i_Switch,
  output logic [NUM_CH-1:0] o_Switch,
  output logic [NUM_CH-1:0] o_Press,
  output logic [NUM_CH-1:0] o_Release,
  output logic [NUM_CH-1:0] o_Long
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
      .LONG_LIMIT     (LONG_LIMIT),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_ch (
      .clk        (i_Clk),
      .rst_n      (i_Rst_L),
      .switch_raw (i_Switch[k]),
      .level      (o_Switch[k]),
      .press      (o_Press[k]),
      .rel        (o_Release[k]),
      .long_press (o_Long[k])
    );
  end

endmodule
